anim_shader: RTL and testbench
==============================

ANIM_SHADER -- requirements
Module: anim_shader

Interface
REQ-001 Parameter COLOR_W, default 12: pixel width. SHALL be a multiple of 3, giving channel width C = COLOR_W/3 (R is the MSB channel).
REQ-002 Parameter BASE_COLOR, default 12'hF00: primary object colour.
REQ-003 Parameter ALT_COLOR, default 12'h000: secondary colour for the checker and blink modes.
REQ-004 Parameter LEVEL, default 1: ordering level of the shader.
REQ-005 Parameter CHECK_LOG2, default 3: checker cell size is 2^CHECK_LOG2 pixels.
REQ-006 Parameter BLINK_FRAMES, default 30, range >=1: frames per blink half-period.
REQ-007 Parameter GRAD_LOG2, default 4: gradient step is one shade per 2^GRAD_LOG2 rows.
REQ-008 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 Port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-010 Ports x, y, input, 10 bits each: coordinates of the pixel currently being printed.
REQ-011 Ports px, py, input, 10 bits each: coordinates of the object's top-left corner.
REQ-012 Port mode_in, input, 2 bits: requested shading mode.
REQ-013 Port frame_tick, input, 1 bit: one-cycle pulse, once per frame.
REQ-014 Port pause, input, 1 bit: freezes all state while high.
REQ-015 Port pixel, output, COLOR_W bits: registered RGB value.
REQ-016 Port level, output, integer: ordering level of the shader.
REQ-017 Port blink_phase, output, 1 bit: current blink phase.

Function
REQ-018 Relative coordinates SHALL be rx = (x - px) mod 1024 and ry = (y - py) mod 1024, i.e. 10-bit wrap-around with no sign handling.
REQ-019 level SHALL equal LEVEL at all times, independent of reset.
REQ-020 cur_mode (2 bits) SHALL load mode_in only on an edge where frame_tick=1 and pause=0; otherwise it holds.
REQ-021 Frame counter fcnt (width clog2(BLINK_FRAMES), minimum 1 bit) SHALL update only on an edge where frame_tick=1 and pause=0:
- if fcnt == BLINK_FRAMES-1: fcnt clears to 0 and blink_phase toggles;
- otherwise: fcnt increments.
REQ-022 The pixel register SHALL update on every edge where pause=0, using the x/y/px/py values and cur_mode sampled at that edge. This gives one-cycle latency.
REQ-023 Mode 0 (solid): pixel = BASE_COLOR.
REQ-024 Mode 1 (checker): pixel = ALT_COLOR when bit0 of ((rx>>CHECK_LOG2) XOR (ry>>CHECK_LOG2)) is 1, else BASE_COLOR.
REQ-025 Mode 2 (blink): pixel = ALT_COLOR when blink_phase=1, else BASE_COLOR.
REQ-026 Mode 3 (gradient): shade = ry>>GRAD_LOG2. Each C-bit channel of BASE_COLOR SHALL be reduced by shade with saturation at 0, computed at full 10-bit width with no truncation of shade.
REQ-027 While pause=1, pixel, fcnt, blink_phase and cur_mode SHALL all hold. A frame_tick coinciding with pause=1 SHALL be ignored, not deferred.
REQ-028 A mode change takes effect on the pixel sampled one edge after the accepting frame_tick edge. It is never applied mid-frame.

Reset
REQ-029 On any edge with reset_n=0, the block SHALL set pixel=0, fcnt=0, blink_phase=0 and cur_mode=0, regardless of pause or frame_tick.
REQ-030 Reset asserted mid-frame or mid-blink SHALL abandon all progress. After release, counting restarts from 0 and phase restarts from 0.
REQ-031 The first edge with reset_n=1 SHALL compute the pixel in mode 0.

Verification
REQ-032 Reset: reset_n=0 for 2 edges -> pixel=0 and blink_phase=0. Release with mode_in=2 and no tick -> pixel=12'hF00 one cycle later.
REQ-033 Checker (CHECK_LOG2=3, px=py=0, mode 1 accepted via tick):
- x=8, y=0 -> pixel=12'h000;
- x=8, y=8 -> pixel=12'hF00;
- x=3, y=1020 with py=1022 (ry wraps to 1022) -> pixel=12'h000.
REQ-034 Blink (BLINK_FRAMES=2, mode 2, x/y held): frame_tick every 10 cycles.
- After tick 2: blink_phase=1, pixel=ALT_COLOR.
- After tick 4: blink_phase=0, pixel=BASE_COLOR.
REQ-035 Pause: from fcnt=1 with pause=1, apply 5 frame_ticks and change x/y each cycle -> fcnt=1, blink_phase and pixel unchanged. Drop pause, then one tick -> blink_phase toggles.
REQ-036 Gradient (BASE_COLOR=12'hF84, GRAD_LOG2=4, mode 3, py=0):
- y=48 -> pixel=12'hC51;
- y=144 -> pixel=12'h600;
- y=1008 -> pixel=12'h000.
REQ-037 Mode latch: mode_in changes 0->1 with no tick -> pixel stays solid. On the tick edge cur_mode=1, and the next edge's pixel follows the checker pattern. Assert reset_n mid-sequence -> mode returns to 0.

Source files
------------

// File: rtl/anim_shader.sv
// Per-pixel object shader: solid, checker, blink and vertical-gradient modes,
// with a frame-synchronous mode latch and a blink counter. One-cycle latency.

module anim_shader_chan #(
  parameter int C = 4
) (
  input  logic [C-1:0] i_ch,
  input  logic [9:0]   i_shade,
  output logic [C-1:0] o_ch
);
  localparam int W = (C > 10) ? C : 10;

  logic [W-1:0] w_ch;
  logic [W-1:0] w_sh;
  logic [W-1:0] w_diff;

  // Saturating subtract done at full shade width so large shades never alias.
  assign w_ch   = W'(i_ch);
  assign w_sh   = W'(i_shade);
  assign w_diff = w_ch - w_sh;
  assign o_ch   = (w_ch > w_sh) ? w_diff[C-1:0] : '0;
endmodule

module anim_shader #(
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] BASE_COLOR   = 12'hF00,
  parameter logic [COLOR_W-1:0] ALT_COLOR    = 12'h000,
  parameter int                 LEVEL        = 1,
  parameter int                 CHECK_LOG2   = 3,
  parameter int                 BLINK_FRAMES = 30,
  parameter int                 GRAD_LOG2    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [9:0]         px,
  input  logic [9:0]         py,
  input  logic [1:0]         mode_in,
  input  logic               frame_tick,
  input  logic               pause,
  output logic [COLOR_W-1:0] pixel,
  output integer             level,
  output logic               blink_phase
);
  localparam int C  = COLOR_W / 3;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    M_SOLID   = 2'd0,
    M_CHECKER = 2'd1,
    M_BLINK   = 2'd2,
    M_GRAD    = 2'd3
  } mode_t;

  mode_t              r_mode;
  logic [FW-1:0]      r_fcnt;
  logic               r_phase;
  logic [COLOR_W-1:0] r_pixel;

  logic [9:0]              w_rx;
  logic [9:0]              w_ry;
  logic [9:0]              w_rxy;
  logic                    w_chk;
  logic [9:0]              w_shade;
  logic [2:0][C-1:0]       w_base_ch;
  logic [2:0][C-1:0]       w_grad_ch;
  logic [COLOR_W-1:0]      w_next;
  logic                    w_accept;

  assign w_rx    = x - px;
  assign w_ry    = y - py;
  // Bit 0 of (rx>>k ^ ry>>k) is just bit k of rx^ry.
  assign w_rxy   = w_rx ^ w_ry;
  assign w_chk   = |(w_rxy & (10'd1 << CHECK_LOG2));
  assign w_shade = w_ry >> GRAD_LOG2;

  assign w_base_ch = BASE_COLOR;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_chan
      anim_shader_chan #(.C(C)) u_chan (
        .i_ch    (w_base_ch[g]),
        .i_shade (w_shade),
        .o_ch    (w_grad_ch[g])
      );
    end
  endgenerate

  always_comb begin
    w_next = BASE_COLOR;
    unique case (r_mode)
      M_SOLID:   w_next = BASE_COLOR;
      M_CHECKER: w_next = w_chk ? ALT_COLOR : BASE_COLOR;
      M_BLINK:   w_next = r_phase ? ALT_COLOR : BASE_COLOR;
      M_GRAD:    w_next = w_grad_ch;
      default:   w_next = BASE_COLOR;
    endcase
  end

  // A tick during pause is dropped, not queued.
  assign w_accept = frame_tick & ~pause;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pixel <= '0;
      r_mode  <= M_SOLID;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!pause) begin
      r_pixel <= w_next;
      if (w_accept) begin
        r_mode <= mode_t'(mode_in);
        if (r_fcnt == FMAX) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign pixel       = r_pixel;
  assign blink_phase = r_phase;
  assign level       = LEVEL;
endmodule

// File: tb/tb_anim_shader.sv
// Scoreboard bench: two differently parameterised shaders share stimulus; a
// reference model predicts each edge and a monitor compares after the edge.

module tb_anim_shader;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x, y, px, py;
  logic [1:0] mode_in;
  logic       frame_tick, pause;
  logic [11:0] pix_a, pix_b;
  integer     lvl_a, lvl_b;
  logic       ph_a, ph_b;

  always #5 clk = ~clk;

  anim_shader #(.BLINK_FRAMES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .px(px), .py(py),
    .mode_in(mode_in), .frame_tick(frame_tick), .pause(pause),
    .pixel(pix_a), .level(lvl_a), .blink_phase(ph_a));

  anim_shader #(.BASE_COLOR(12'hF84), .ALT_COLOR(12'h3C7), .LEVEL(5),
                .CHECK_LOG2(2), .BLINK_FRAMES(3), .GRAD_LOG2(4)) u_b (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .px(px), .py(py),
    .mode_in(mode_in), .frame_tick(frame_tick), .pause(pause),
    .pixel(pix_b), .level(lvl_b), .blink_phase(ph_b));

  int BASE [2] = '{12'hF00, 12'hF84};
  int ALT  [2] = '{12'h000, 12'h3C7};
  int CL   [2] = '{3, 2};
  int BF   [2] = '{2, 3};
  int GL   [2] = '{4, 4};

  int   m_fcnt [2];
  bit   m_ph   [2];
  int   m_mode [2];
  int   m_pix  [2];

  typedef struct {
    int pa; bit pha; int pb; bit phb;
    bit ca; int la; bit cb; int lb;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int shade_px(input int k, input int mode, input bit ph,
                                  input int xx, input int yy, input int pxx, input int pyy);
    int rx, ry, sh, r, v;
    rx = (xx - pxx + 1024) % 1024;
    ry = (yy - pyy + 1024) % 1024;
    case (mode)
      1: return ((((rx >> CL[k]) ^ (ry >> CL[k])) % 2) == 1) ? ALT[k] : BASE[k];
      2: return ph ? ALT[k] : BASE[k];
      3: begin
        sh = ry >> GL[k];
        r = 0;
        for (int c = 0; c < 3; c++) begin
          v = (BASE[k] / (1 << (4 * c))) % 16;
          v = (v > sh) ? v - sh : 0;
          r += v * (1 << (4 * c));
        end
        return r;
      end
      default: return BASE[k];
    endcase
  endfunction

  // Advance the model by one edge with the current inputs and queue the result.
  task automatic step(input bit ca = 0, input int la = 0, input bit cb = 0, input int lb = 0);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_pix[k] = 0; m_fcnt[k] = 0; m_ph[k] = 0; m_mode[k] = 0;
      end else if (!pause) begin
        m_pix[k] = shade_px(k, m_mode[k], m_ph[k], x, y, px, py);
        if (frame_tick) begin
          m_mode[k] = mode_in;
          if (m_fcnt[k] == BF[k] - 1) begin
            m_fcnt[k] = 0; m_ph[k] = ~m_ph[k];
          end else m_fcnt[k]++;
        end
      end
    end
    e.pa = m_pix[0]; e.pha = m_ph[0]; e.pb = m_pix[1]; e.phb = m_ph[1];
    e.ca = ca; e.la = la; e.cb = cb; e.lb = lb;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_in(input int xx, input int yy, input int pxx, input int pyy,
                        input int md, input bit tk, input bit ps, input bit rn);
    x = 10'(xx); y = 10'(yy); px = 10'(pxx); py = 10'(pyy);
    mode_in = 2'(md); frame_tick = tk; pause = ps; reset_n = rn;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pix_a", int'(pix_a), e.pa);
        chk("phase_a", int'(ph_a), int'(e.pha));
        chk("pix_b", int'(pix_b), e.pb);
        chk("phase_b", int'(ph_b), int'(e.phb));
        if (e.ca) chk("lit_a", int'(pix_a), e.la);
        if (e.cb) chk("lit_b", int'(pix_b), e.lb);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // Reset for two edges, then release with mode 2 requested but no tick.
    step(1, 12'h000, 1, 12'h000);
    step(1, 12'h000, 1, 12'h000);
    set_in(0, 0, 0, 0, 2, 0, 0, 1);
    step(1, 12'hF00, 1, 12'hF84);

    // Mode request without tick stays solid; tick edge still solid; then checker.
    set_in(8, 0, 0, 0, 1, 0, 0, 1); step(1, 12'hF00);
    set_in(8, 0, 0, 0, 1, 1, 0, 1); step(1, 12'hF00);
    set_in(8, 0, 0, 0, 1, 0, 0, 1); step(1, 12'h000);
    set_in(8, 8, 0, 0, 1, 0, 0, 1); step(1, 12'hF00);
    set_in(3, 1020, 0, 1022, 1, 0, 0, 1); step(1, 12'h000);
    // Reset mid-sequence drops the latched mode back to solid.
    set_in(8, 0, 0, 0, 1, 0, 0, 0); step(1, 12'h000);
    set_in(8, 0, 0, 0, 1, 0, 0, 1); step(1, 12'hF00);

    // Blink: ticks every 10 cycles, x/y held.
    set_in(5, 5, 0, 0, 2, 0, 0, 0); step();
    for (int t = 1; t <= 4; t++) begin
      set_in(5, 5, 0, 0, 2, 1, 0, 1); step();
      for (int c = 0; c < 9; c++) begin
        set_in(5, 5, 0, 0, 2, 0, 0, 1);
        if (c == 0 && t == 2) step(1, 12'h000);
        else if (c == 0 && t == 4) step(1, 12'hF00);
        else step();
      end
    end
    // Reset mid-blink, then count again from zero.
    set_in(5, 5, 0, 0, 2, 1, 0, 1); step();
    set_in(5, 5, 0, 0, 2, 0, 0, 0); step();
    for (int c = 0; c < 6; c++) begin
      set_in(5, 5, 0, 0, 2, (c % 2) == 0, 0, 1); step();
    end

    // Pause: reach fcnt=1 on the A shader, then ticks and moving x/y are ignored.
    set_in(0, 0, 0, 0, 2, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 2, 1, 0, 1); step();
    set_in(0, 0, 0, 0, 2, 0, 0, 1); step(1, 12'hF00);
    for (int c = 0; c < 10; c++) begin
      set_in(c * 37, c * 91, 0, 0, 3, c % 2, 1, 1); step(1, 12'hF00);
    end
    set_in(0, 0, 0, 0, 2, 1, 0, 1); step(1, 12'hF00);
    set_in(0, 0, 0, 0, 2, 0, 0, 1); step(1, 12'h000);

    // Gradient.
    set_in(0, 0, 0, 0, 3, 1, 0, 1); step();
    set_in(0, 48, 0, 0, 3, 0, 0, 1); step(1, 12'hC00, 1, 12'hC51);
    set_in(0, 144, 0, 0, 3, 0, 0, 1); step(1, 12'h600, 1, 12'h600);
    set_in(0, 1008, 0, 0, 3, 0, 0, 1); step(1, 12'h000, 1, 12'h000);
    set_in(0, 20, 0, 30, 3, 0, 0, 1); step(1, 12'h000, 1, 12'h000);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 1023), $urandom_range(0, 1023),
             $urandom_range(0, 1023), $urandom_range(0, 1023),
             $urandom_range(0, 3), $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 99) != 0);
      step();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("level_a", lvl_a, 1);
    chk("level_b", lvl_b, 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
